mem_wb_skid_latch: RTL and testbench

Parametrised successor to the fixed-width MEM/WB pipeline latch. It carries the write-back payload (WB control, memory read data, ALU result, destination register) from MEM to WB using a valid/ready elastic handshake with a 2-entry skid buffer. It also supports stall back-pressure and flush (bubble insertion). It sits between the memory stage and the write-back mux/register file.

---
 rtl/mem_wb_skid_latch.sv | 96 +++++++++
 tb/tb_mem_wb_skid_latch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_latch.sv
// MEM/WB elastic pipeline latch: valid/ready handshake with a main + skid register pair,
// stall back-pressure, flush bubble insertion and a registered occupancy count.
module mem_wb_skid_latch #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_wb_in,
    input  logic [DATA_W-1:0] Read_data_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [REG_W-1:0]  Write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] mem_control_wb,
    output logic [DATA_W-1:0] Read_data,
    output logic [DATA_W-1:0] mem_ALU_result,
    output logic [REG_W-1:0]  mem_Write_reg,
    output logic [1:0]        occupancy
);

    localparam int PAY_W = CTRL_W + 2 * DATA_W + REG_W;

    logic [PAY_W-1:0] in_pay_p0;
    logic [PAY_W-1:0] main_pay_p1, main_pay_n;
    logic [PAY_W-1:0] skid_pay_p1, skid_pay_n;
    logic             main_vld_p1, main_vld_n;
    logic             skid_vld_p1, skid_vld_n;
    logic [1:0]       occ_p1;
    logic             accept, drain, load_main;

    assign in_pay_p0 = {control_wb_in, Read_data_in, ALU_result_in, Write_reg_in};

    // in_ready depends on registered state only, so out_ready never reaches it combinationally.
    assign in_ready  = reset & ~skid_vld_p1;
    assign accept    = in_valid & in_ready;
    assign drain     = main_vld_p1 & out_ready;
    assign load_main = ~main_vld_p1 | drain;

    always_comb begin
        main_pay_n = main_pay_p1;
        skid_pay_n = skid_pay_p1;
        main_vld_n = main_vld_p1;
        skid_vld_n = skid_vld_p1;
        if (load_main) begin
            if (skid_vld_p1) begin
                main_pay_n = skid_pay_p1;
                main_vld_n = 1'b1;
                skid_vld_n = 1'b0;
            end else if (accept) begin
                main_pay_n = in_pay_p0;
                main_vld_n = 1'b1;
            end else begin
                main_vld_n = 1'b0;
            end
        end else if (accept) begin
            skid_pay_n = in_pay_p0;
            skid_vld_n = 1'b1;
        end
        // Flush squashes held and incoming entries; a same-cycle drain has already been consumed.
        if (flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end
    end

    // ---- stage p1: main/skid storage ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_pay_p1 <= '0;
            skid_pay_p1 <= '0;
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            occ_p1      <= 2'd0;
        end else begin
            main_pay_p1 <= main_pay_n;
            skid_pay_p1 <= skid_pay_n;
            main_vld_p1 <= main_vld_n;
            skid_vld_p1 <= skid_vld_n;
            occ_p1      <= {1'b0, main_vld_n} + {1'b0, skid_vld_n};
        end
    end

    // Control is masked on bubbles so an invalid slot can never assert RegWrite.
    assign out_valid      = main_vld_p1;
    assign mem_control_wb = main_vld_p1 ? main_pay_p1[PAY_W-1 -: CTRL_W] : '0;
    assign Read_data      = main_pay_p1[REG_W + DATA_W +: DATA_W];
    assign mem_ALU_result = main_pay_p1[REG_W +: DATA_W];
    assign mem_Write_reg  = main_pay_p1[REG_W-1:0];
    assign occupancy      = occ_p1;

endmodule

// File: tb/tb_mem_wb_skid_latch.sv
// Self-checking bench for mem_wb_skid_latch: directed scenario tasks plus a FIFO scoreboard
// that records accepted payloads and checks every drained one in order.
module tb_mem_wb_skid_latch;

    localparam int CTRL_W = 2;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int PAY_W  = CTRL_W + 2 * DATA_W + REG_W;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] control_wb_in, mem_control_wb;
    logic [DATA_W-1:0] Read_data_in, ALU_result_in, Read_data, mem_ALU_result;
    logic [REG_W-1:0]  Write_reg_in, mem_Write_reg;
    logic [1:0]        occupancy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [PAY_W-1:0] sb_q[$];
    logic [PAY_W-1:0] exp_pay, got_pay;

    mem_wb_skid_latch #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .control_wb_in(control_wb_in), .Read_data_in(Read_data_in),
        .ALU_result_in(ALU_result_in), .Write_reg_in(Write_reg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_control_wb(mem_control_wb), .Read_data(Read_data),
        .mem_ALU_result(mem_ALU_result), .mem_Write_reg(mem_Write_reg),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: inputs change only just after posedge, so negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            sb_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                got_pay = {mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg};
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, expected no output", got_pay);
                end else begin
                    exp_pay = sb_q.pop_front();
                    if (got_pay !== exp_pay) begin
                        n_fail++;
                        $display("FAIL sb_order: got %h, expected %h", got_pay, exp_pay);
                    end
                end
            end
            if (flush === 1'b1)
                sb_q.delete();
            else if (in_valid === 1'b1 && in_ready === 1'b1)
                sb_q.push_back({control_wb_in, Read_data_in, ALU_result_in, Write_reg_in});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] rd,
                         input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr);
        in_valid      = v;
        control_wb_in = c;
        Read_data_in  = rd;
        ALU_result_in = alu;
        Write_reg_in  = wr;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 2'b11, 32'hFFFF_0000, 32'h1234, 5'd3);
        tick();
        tick();
        n_cmp++;
        if ({in_ready, out_valid, occupancy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b vld=%b occ=%0d, expected 0 0 0", in_ready, out_valid, occupancy);
        end
        n_cmp++;
        if ({mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h, expected all zero",
                     mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg);
        end
        reset = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready got %b, expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_streaming();
        int vld_cycles = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 32'h100 + i, 32'h10 * (i + 1), 5'(5 + i));
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || mem_ALU_result !== 32'h10 * (i + 1) || mem_Write_reg !== 5'(5 + i)) begin
                n_fail++;
                $display("FAIL stream_%0d: got vld=%b alu=%h reg=%0d, expected 1 %h %0d",
                         i, out_valid, mem_ALU_result, mem_Write_reg, 32'h10 * (i + 1), 5 + i);
            end
            n_cmp++;
            if (occupancy !== 2'd1) begin
                n_fail++;
                $display("FAIL stream_occ_%0d: got %0d, expected 1", i, occupancy);
            end
            if (out_valid === 1'b1) vld_cycles++;
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        if (out_valid === 1'b1) vld_cycles++;
        n_cmp++;
        if (vld_cycles != 3 || occupancy !== 2'd0 || mem_control_wb !== 2'b00) begin
            n_fail++;
            $display("FAIL stream_end: got vld_cycles=%0d occ=%0d ctrl=%b, expected 3 0 00",
                     vld_cycles, occupancy, mem_control_wb);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hA0, 32'hA, 5'd10);
        tick();
        drive(1'b1, 2'b01, 32'hB0, 32'hB, 5'd11);
        tick();
        n_cmp++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d rdy=%b, expected 2 0", occupancy, in_ready);
        end
        drive(1'b1, 2'b01, 32'hC0, 32'hC, 5'd12);
        tick();
        n_cmp++;
        if (occupancy !== 2'd2 || mem_ALU_result !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_hold: got occ=%0d alu=%h, expected 2 a", occupancy, mem_ALU_result);
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || mem_ALU_result !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain_b: got vld=%b alu=%h occ=%0d rdy=%b, expected 1 b 1 1",
                     out_valid, mem_ALU_result, occupancy, in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || mem_ALU_result !== 32'hC || occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_drain_c: got vld=%b alu=%h occ=%0d, expected 1 c 1",
                     out_valid, mem_ALU_result, occupancy);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_empty: got vld=%b occ=%0d, expected 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hA1, 32'hA, 5'd1);
        tick();
        drive(1'b1, 2'b01, 32'hB1, 32'hB, 5'd2);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b01, 32'hC1, 32'hC, 5'd3);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || mem_control_wb !== 2'b00 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_full: got vld=%b ctrl=%b occ=%0d, expected 0 00 0",
                     out_valid, mem_control_wb, occupancy);
        end
        // Flush while an accept is possible: the incoming payload must be dropped too.
        flush = 1'b0;
        drive(1'b1, 2'b01, 32'hD1, 32'hD, 5'd4);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b11, 32'hE1, 32'hE, 5'd5);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || mem_control_wb !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_accept: got vld=%b occ=%0d ctrl=%b, expected 0 0 00",
                     out_valid, occupancy, mem_control_wb);
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: out_valid got %b, expected 0", out_valid);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h77, 5'd9);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || mem_control_wb !== 2'b11 || Read_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bubble_load: got vld=%b ctrl=%b rd=%h, expected 1 11 deadbeef",
                     out_valid, mem_control_wb, Read_data);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || mem_control_wb !== 2'b00 || Read_data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bubble_mask: got vld=%b ctrl=%b rd=%h, expected 0 00 deadbeef",
                     out_valid, mem_control_wb, Read_data);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'h11, 32'h31, 5'd1);
        tick();
        drive(1'b1, 2'b01, 32'h22, 32'h32, 5'd2);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        n_cmp++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
            {mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got occ=%0d vld=%b rdy=%b alu=%h, expected 0 0 0 0",
                     occupancy, out_valid, in_ready, mem_ALU_result);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 32'h5500, 32'h55, 5'd21);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || mem_ALU_result !== 32'h55 || occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL rstmid_first: got vld=%b alu=%h occ=%0d, expected 1 55 1",
                     out_valid, mem_ALU_result, occupancy);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_empty: got vld=%b occ=%0d, expected 0 0", out_valid, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_reset_mid();
        tick();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d undrained entries, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
